// File: rtl/inst_loader.sv
// inst_loader: program loader and instruction store for a small processor.
//   Bytes are streamed in over a valid/ready handshake into a 256 x 8 store.
//   Once the final byte has been taken, the processor is released from reset
//   and fetches instructions combinationally by pc.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   load_start          - begin (re)loading a program (IDLE or RUN only)
//   load_valid/data/last- byte stream; last marks the final byte
//   load_ready          - high while loading; a byte is taken on valid&&ready
//   pc / instruction    - fetch address and zero-latency instruction (FILL
//                         outside the loaded program or when not running)
//   cpu_reset           - hold-reset request to the processor (low only in RUN)
//   state               - IDLE=00, LOAD=01, RUN=10
//   prog_len            - bytes loaded in the current program (0..256)
//   checksum            - XOR of all bytes taken in the current load
module inst_loader #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_reset,
  output logic [1:0] state,
  output logic [8:0] prog_len,
  output logic [7:0] checksum
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [8:0] prog_len_q, prog_len_d;
  logic [7:0] checksum_q, checksum_d;
  logic       mem_we;
  logic       accept;

  // Program store; deliberately never cleared so reset costs no cycles.
  logic [7:0] mem [256];

  assign load_ready = (state_q == ST_LOAD);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    checksum_d = checksum_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          checksum_d = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we     = !reset;
          wr_ptr_d   = wr_ptr_q + 8'd1;
          prog_len_d = {1'b0, wr_ptr_q} + 9'd1;
          checksum_d = checksum_q ^ load_data;
          // The store is full after the byte at 255, so it ends the load.
          if (load_last || (wr_ptr_q == 8'hFF)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      checksum_q <= checksum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

  assign state     = state_q;
  assign prog_len  = prog_len_q;
  assign checksum  = checksum_q;
  assign cpu_reset = (state_q != ST_RUN);

  assign instruction = ((state_q == ST_RUN) && ({1'b0, pc} < prog_len_q)) ? mem[pc] : FILL;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: directed vector table, a full 256-byte load,
// and randomized traffic checked against a queue-based program model.
module tb_inst_loader;

  localparam logic [7:0] FILL_V = 8'hEA;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic [7:0] pc = '0;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic [1:0] state;
  logic [8:0] prog_len;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_bad = 0;

  inst_loader #(.FILL(FILL_V)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc         (pc),
    .instruction(instruction),
    .cpu_reset  (cpu_reset),
    .state      (state),
    .prog_len   (prog_len),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 loading, 2 running. The program is the queue of bytes
  // taken in the current load; model_mem persists across loads and resets.
  int         mode = 0;
  logic [7:0] prog[$];
  logic [7:0] model_mem [256];

  function automatic void model_step();
    if (reset) begin
      mode = 0;
      prog.delete();
    end else if (mode == 0 || mode == 2) begin
      if (load_start) begin
        mode = 1;
        prog.delete();
      end
    end else if (load_valid) begin
      model_mem[prog.size()] = load_data;
      prog.push_back(load_data);
      if (load_last || prog.size() == 256) mode = 2;
    end
  endfunction

  function automatic logic [7:0] model_cks();
    logic [7:0] x = '0;
    foreach (prog[i]) x ^= prog[i];
    return x;
  endfunction

  function automatic logic [7:0] model_instr(input logic [7:0] a);
    if (mode == 2 && int'(a) < prog.size()) return model_mem[a];
    return FILL_V;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 16'(state), 16'(mode));
    chk({tag, ".ready"}, 16'(load_ready), 16'(mode == 1));
    chk({tag, ".cpu_reset"}, 16'(cpu_reset), 16'(mode != 2));
    chk({tag, ".prog_len"}, 16'(prog_len), 16'(prog.size()));
    chk({tag, ".checksum"}, 16'(checksum), 16'(model_cks()));
    chk({tag, ".instr"}, 16'(instruction), 16'(model_instr(pc)));
  endtask

  // Drive inputs, advance the model past the coming edge, then sample.
  task automatic cycle(input logic r, input logic s, input logic v,
                       input logic [7:0] d, input logic l, input logic [7:0] a);
    reset = r; load_start = s; load_valid = v; load_data = d; load_last = l; pc = a;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       r, s, v;
    logic [7:0] d;
    logic       l;
    logic [7:0] a;
    logic [1:0] e_state;
    logic       e_ready, e_cpu;
    logic [8:0] e_len;
    logic [7:0] e_cks, e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, s, v, input logic [7:0] d, input logic l,
                     input logic [7:0] a, input logic [1:0] es, input logic er, ec,
                     input logic [8:0] el, input logic [7:0] ek, ei);
    vec_t t;
    t = '{r:r, s:s, v:v, d:d, l:l, a:a, e_state:es, e_ready:er, e_cpu:ec,
          e_len:el, e_cks:ek, e_instr:ei};
    vecs.push_back(t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    //   r s v data  l  pc    st    rdy cpu len   cks    instr
    add(1,0,0,8'h00,0,8'h00, 2'b00,0,1, 9'd0, 8'h00, FILL_V);  // reset
    add(0,1,1,8'hEE,0,8'h00, 2'b01,1,1, 9'd0, 8'h00, FILL_V);  // start+valid: no accept
    add(0,0,1,8'h12,0,8'h00, 2'b01,1,1, 9'd1, 8'h12, FILL_V);
    add(0,0,0,8'h99,1,8'h00, 2'b01,1,1, 9'd1, 8'h12, FILL_V);  // last w/o valid
    add(0,1,1,8'h34,0,8'h00, 2'b01,1,1, 9'd2, 8'h26, FILL_V);  // start ignored in LOAD
    add(0,0,1,8'h56,1,8'h01, 2'b10,0,0, 9'd3, 8'h70, 8'h34);   // last -> RUN
    add(0,0,0,8'h00,0,8'h03, 2'b10,0,0, 9'd3, 8'h70, FILL_V);
    add(0,0,0,8'h00,0,8'h02, 2'b10,0,0, 9'd3, 8'h70, 8'h56);
    add(0,0,0,8'h00,0,8'h00, 2'b10,0,0, 9'd3, 8'h70, 8'h12);
    add(0,1,0,8'h00,0,8'h00, 2'b01,1,1, 9'd0, 8'h00, FILL_V);  // reload from RUN
    add(0,0,1,8'hA5,0,8'h00, 2'b01,1,1, 9'd1, 8'hA5, FILL_V);
    add(0,0,0,8'h77,0,8'h00, 2'b01,1,1, 9'd1, 8'hA5, FILL_V);  // idle cycle
    add(0,0,1,8'h5A,1,8'h01, 2'b10,0,0, 9'd2, 8'hFF, 8'h5A);
    add(0,0,0,8'h00,0,8'h00, 2'b10,0,0, 9'd2, 8'hFF, 8'hA5);
    add(0,0,0,8'h00,0,8'h02, 2'b10,0,0, 9'd2, 8'hFF, FILL_V);  // stale byte hidden
    add(0,1,0,8'h00,0,8'h00, 2'b01,1,1, 9'd0, 8'h00, FILL_V);
    add(0,0,1,8'hC3,1,8'h00, 2'b10,0,0, 9'd1, 8'hC3, 8'hC3);
    add(0,0,0,8'h00,0,8'h01, 2'b10,0,0, 9'd1, 8'hC3, FILL_V);
    add(0,1,0,8'h00,0,8'h00, 2'b01,1,1, 9'd0, 8'h00, FILL_V);
    add(0,0,1,8'h11,0,8'h00, 2'b01,1,1, 9'd1, 8'h11, FILL_V);
    add(0,0,1,8'h22,0,8'h00, 2'b01,1,1, 9'd2, 8'h33, FILL_V);
    add(1,0,1,8'h33,0,8'h00, 2'b00,0,1, 9'd0, 8'h00, FILL_V);  // reset mid-load
    add(0,0,1,8'h44,1,8'h01, 2'b00,0,1, 9'd0, 8'h00, FILL_V);  // valid ignored in IDLE
    add(0,0,0,8'h00,0,8'h00, 2'b00,0,1, 9'd0, 8'h00, FILL_V);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].a);
      chk($sformatf("vec%0d.state", i), 16'(state), 16'(vecs[i].e_state));
      chk($sformatf("vec%0d.ready", i), 16'(load_ready), 16'(vecs[i].e_ready));
      chk($sformatf("vec%0d.cpu_reset", i), 16'(cpu_reset), 16'(vecs[i].e_cpu));
      chk($sformatf("vec%0d.prog_len", i), 16'(prog_len), 16'(vecs[i].e_len));
      chk($sformatf("vec%0d.checksum", i), 16'(checksum), 16'(vecs[i].e_cks));
      chk($sformatf("vec%0d.instr", i), 16'(instruction), 16'(vecs[i].e_instr));
    end

    // Reset with pc swept: nothing readable.
    for (int a = 0; a < 256; a += 37) begin
      pc = 8'(a);
      #1;
      chk("idle_sweep.instr", 16'(instruction), 16'(FILL_V));
    end

    // Full 256-byte load, value = index, load_last never set.
    cycle(0, 1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      cycle(0, 0, 1, 8'(i), 0, 8'hFF);
      if (i == 254) chk("full.state_before_last", 16'(state), 16'h1);
    end
    chk("full.state", 16'(state), 16'h2);
    chk("full.prog_len", 16'(prog_len), 16'd256);
    chk("full.checksum", 16'(checksum), 16'h00);
    chk("full.instr255", 16'(instruction), 16'hFF);
    cycle(0, 0, 1, 8'hAB, 1, 8'h80);  // valid in RUN is not taken
    chk("full.instr128", 16'(instruction), 16'h80);
    chk("full.prog_len_hold", 16'(prog_len), 16'd256);
    check_model("full");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic r, s, v, l;
      logic [7:0] d, a;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      cycle(r, s, v, d, l, a);
      check_model("rand");
      if (n_bad > 20) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
